// File: rtl/apb_uart_master_pkg.sv
// Shared definitions for the APB UART master: FSM state encoding and the
// UART register map seen on the APB side.
package apb_uart_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [7:0] UART_CTRL_ADDR = 8'h00;
  localparam logic [7:0] UART_TX_ADDR   = 8'h04;
  localparam logic [7:0] UART_STAT_ADDR = 8'h08;
  localparam logic [7:0] UART_RX_ADDR   = 8'h0C;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter with a per-request mask. ptr names the
// requester favoured on the next tie; it moves on every accepted grant.
module apb_rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic [1:0] eligible;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    eligible = req & ~mask;
    grant    = 2'b00;
    unique case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      ptr <= 1'b0;
    else if (advance && |grant)
      ptr <= ~grant[1];
  end

endmodule

// File: rtl/apb_uart_master.sv
// Two-requester APB master for the UART register block: arbitrates, runs
// one SETUP/ACCESS transfer per grant and returns ack/err/rdata.
module apb_uart_master
  import apb_uart_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ack,
  output logic [7:0] req0_rdata,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ack,
  output logic [7:0] req1_rdata,
  output logic       req1_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e      state, state_next;
  logic [1:0]      grant;
  logic            rr_ptr;
  logic            gnt_idx;
  logic [CW-1:0]   cnt;
  logic [1:0]      ack_q, err_q;
  logic [1:0][7:0] rdata_q;
  logic            done_ok, done_to;

  // A requester acknowledged this cycle still holds valid; mask it so it
  // is not re-granted for the request that just finished.
  apb_rr_arb2 u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     ({req1_valid, req0_valid}),
    .mask    (ack_q),
    .advance (state == ST_IDLE),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  always_comb begin
    state_next = state;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    unique case (state)
      ST_IDLE:   if (|grant) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          done_ok    = 1'b1;
          state_next = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          done_to    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE  <= 1'b0;
      PADDR   <= 8'h00;
      PWDATA  <= 8'h00;
      gnt_idx <= 1'b0;
      cnt     <= '0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      ack_q <= 2'b00;
      err_q <= 2'b00;
      if (state == ST_IDLE && |grant) begin
        gnt_idx <= grant[1];
        PWRITE  <= grant[1] ? req1_write : req0_write;
        PADDR   <= grant[1] ? req1_addr  : req0_addr;
        PWDATA  <= grant[1] ? req1_wdata : req0_wdata;
        cnt     <= '0;
      end
      if (state == ST_ACCESS && !PREADY)
        cnt <= cnt + CW'(1);
      if (done_ok || done_to) begin
        ack_q[gnt_idx] <= 1'b1;
        err_q[gnt_idx] <= done_to;
        if (done_to)
          rdata_q[gnt_idx] <= 8'h00;
        else if (!PWRITE)
          rdata_q[gnt_idx] <= PRDATA;
      end
    end
  end

  assign PSEL       = (state != ST_IDLE);
  assign PENABLE    = (state == ST_ACCESS);
  assign busy       = (state != ST_IDLE);
  assign req0_ack   = ack_q[0];
  assign req1_ack   = ack_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata_q[0];
  assign req1_rdata = rdata_q[1];

endmodule

// File: tb/tb_apb_uart_master.sv
// Directed bench for apb_uart_master: single transfers, wait states,
// arbitration ties, timeout, mid-transfer reset and out-of-phase PREADY.
module tb_apb_uart_master;
  import apb_uart_master_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ack, req0_err, req1_ack, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic       PSEL, PENABLE, PWRITE, PREADY, busy;
  logic [7:0] PADDR, PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  int         n_psel, n_pen, lat;
  logic [1:0] acks, errs;

  apb_uart_master #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Runs the bus until some ack appears. In ACCESS, PREADY rises on the
  // ready_after-th cycle (0 = never); outside ACCESS it is idle_ready with
  // PRDATA=0xFF so stray completions would be visible.
  task automatic run_xfer(input int ready_after, input logic idle_ready,
                          input logic [7:0] acc_rdata, input logic exp_write,
                          input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                          output int o_psel, output int o_pen, output int o_lat,
                          output logic [1:0] o_acks, output logic [1:0] o_errs);
    o_psel = 0; o_pen = 0; o_lat = 0; o_acks = 2'b00; o_errs = 2'b00;
    PREADY = idle_ready;
    PRDATA = 8'hFF;
    for (int i = 0; i < 60 && o_acks == 2'b00; i++) begin
      tick();
      o_lat++;
      if (PSEL) begin
        o_psel++;
        check("paddr_stable", PADDR, exp_addr);
        check("pwrite_stable", PWRITE, exp_write);
        if (exp_write) check("pwdata_stable", PWDATA, exp_wdata);
      end
      if (PENABLE) begin
        o_pen++;
        PREADY = (ready_after != 0 && o_pen >= ready_after);
        PRDATA = acc_rdata;
      end else begin
        PREADY = idle_ready;
        PRDATA = 8'hFF;
      end
      o_acks = {req1_ack, req0_ack};
      o_errs = {req1_err, req0_err};
    end
    if (o_acks == 2'b00) check("ack_within_bound", 0, 1);
    PREADY = 1'b0;
    PRDATA = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    PREADY = 0; PRDATA = 0;
    tick(); tick();
    PRESET = 1'b0;
    tick();

    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_rdata", {req1_rdata, req0_rdata}, 16'h0000);

    // req0 write 0xD4 to TX with two wait states
    req0_valid = 1; req0_write = 1; req0_addr = UART_TX_ADDR; req0_wdata = 8'hD4;
    run_xfer(3, 1'b0, 8'h00, 1'b1, 8'h04, 8'hD4, n_psel, n_pen, lat, acks, errs);
    check("wr_psel_cycles", n_psel, 4);
    check("wr_penable_cycles", n_pen, 3);
    check("wr_latency", lat, 5);
    check("wr_acks", acks, 2'b01);
    check("wr_errs", errs, 2'b00);
    check("wr_rdata_hold", req0_rdata, 8'h00);
    tick();
    req0_valid = 0;
    check("wr_ack_pulse", {req1_ack, req0_ack}, 2'b00);
    check("wr_masked_no_regrant", busy, 0);
    check("wr_paddr_hold_idle", PADDR, 8'h04);

    // PREADY/PRDATA active in IDLE must not complete anything
    PREADY = 1; PRDATA = 8'hFF;
    tick(); tick();
    check("idle_ready_no_ack", {req1_ack, req0_ack}, 2'b00);
    check("idle_ready_rdata", req1_rdata, 8'h00);
    check("idle_ready_busy", busy, 0);

    // req1 read RX, ready on first ACCESS, PREADY high in IDLE/SETUP
    req1_valid = 1; req1_write = 0; req1_addr = UART_RX_ADDR;
    run_xfer(1, 1'b1, 8'h5A, 1'b0, 8'h0C, 8'h00, n_psel, n_pen, lat, acks, errs);
    check("rd_latency", lat, 3);
    check("rd_penable_cycles", n_pen, 1);
    check("rd_acks", acks, 2'b10);
    check("rd_errs", errs, 2'b00);
    check("rd_rdata", req1_rdata, 8'h5A);
    tick();
    req1_valid = 0;

    // Timeout on req1 read: 16 ACCESS cycles, err, rdata cleared
    req1_valid = 1; req1_write = 0; req1_addr = UART_STAT_ADDR;
    run_xfer(0, 1'b0, 8'h77, 1'b0, 8'h08, 8'h00, n_psel, n_pen, lat, acks, errs);
    check("to_penable_cycles", n_pen, 16);
    check("to_acks", acks, 2'b10);
    check("to_errs", errs, 2'b10);
    check("to_rdata", req1_rdata, 8'h00);
    check("to_busy", busy, 0);
    tick();
    req1_valid = 0;

    // Fresh reset, then a tie: req0 first, req1 next, then req0 again
    PRESET = 1; tick(); PRESET = 0; tick();
    req0_valid = 1; req0_write = 1; req0_addr = UART_CTRL_ADDR; req0_wdata = 8'h11;
    req1_valid = 1; req1_write = 1; req1_addr = UART_TX_ADDR;   req1_wdata = 8'h22;
    run_xfer(1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h11, n_psel, n_pen, lat, acks, errs);
    check("tie1_acks", acks, 2'b01);
    tick();
    req0_valid = 0;
    check("tie1_req1_granted", busy, 1);
    run_xfer(1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h22, n_psel, n_pen, lat, acks, errs);
    check("tie2_acks", acks, 2'b10);
    tick();
    req1_valid = 0;
    tick();
    req0_valid = 1; req0_addr = UART_TX_ADDR; req0_wdata = 8'h33;
    req1_valid = 1; req1_addr = UART_CTRL_ADDR; req1_wdata = 8'h44;
    run_xfer(1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h33, n_psel, n_pen, lat, acks, errs);
    check("tie3_acks", acks, 2'b01);
    req1_valid = 0;
    tick();
    req0_valid = 0;
    tick();

    // Reset mid-ACCESS of a req0 transfer: abandon, then req0 favoured
    req0_valid = 1; req0_write = 1; req0_addr = UART_CTRL_ADDR; req0_wdata = 8'h03;
    tick(); tick();
    check("mid_in_access", PENABLE, 1);
    PRESET = 1;
    req0_valid = 0;
    #1;
    check("mid_rst_psel_pen", {PSEL, PENABLE}, 2'b00);
    check("mid_rst_bus", {PWRITE, PADDR, PWDATA}, 17'h0);
    check("mid_rst_busy", busy, 0);
    tick();
    PRESET = 0;
    PREADY = 1;
    tick(); tick();
    check("mid_rst_no_ack", {req1_ack, req0_ack}, 2'b00);
    PREADY = 0;
    req0_valid = 1; req0_write = 0; req0_addr = UART_STAT_ADDR;
    req1_valid = 1; req1_write = 1; req1_addr = UART_TX_ADDR; req1_wdata = 8'h55;
    run_xfer(1, 1'b0, 8'h21, 1'b0, 8'h08, 8'h00, n_psel, n_pen, lat, acks, errs);
    check("post_rst_acks", acks, 2'b01);
    check("post_rst_latency", lat, 3);
    check("post_rst_rdata", req0_rdata, 8'h21);
    req1_valid = 0;
    tick();
    req0_valid = 0;
    tick();
    check("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_master.md
APB_UART_MASTER -- requirements
Module: apb_uart_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of ACCESS cycles waiting for PREADY; 0 disables the timeout.
REQ-002 SHALL have port PCLK, input, 1: the single clock; all logic rising-edge.
REQ-003 SHALL have port PRESET, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid (N=0,1), input, 1: requester N has a pending transfer.
REQ-005 SHALL have ports reqN_write, input, 1: 1 = APB write, 0 = APB read.
REQ-006 SHALL have ports reqN_addr, input, 8: APB target address (UART map: 0x00 ctrl, 0x04 TX data, 0x08 status, 0x0C RX data).
REQ-007 SHALL have ports reqN_wdata, input, 8: write data.
REQ-008 SHALL have ports reqN_ack, output, 1: one-cycle completion pulse to requester N.
REQ-009 SHALL have ports reqN_rdata, output, 8: read data of the last completed read.
REQ-010 SHALL have ports reqN_err, output, 1: completion was a timeout; valid while reqN_ack=1.
REQ-011 SHALL have APB master outputs PSEL (1), PENABLE (1), PWRITE (1), PADDR (8), PWDATA (8).
REQ-012 SHALL have APB master inputs PRDATA (8) and PREADY (1).
REQ-013 SHALL have output busy, 1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE, one transfer per pass, no back-to-back bypass of IDLE.
REQ-015 In IDLE with any unmasked reqN_valid, SHALL grant one requester, latch its write/addr/wdata, and enter SETUP next cycle.
REQ-016 Arbitration SHALL be round-robin: sole requester wins; on a tie, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-017 A requester whose reqN_ack is high in the current cycle SHALL be masked from arbitration that cycle.
REQ-018 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0; ACCESS SHALL drive PSEL=1, PENABLE=1.
REQ-019 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through the last ACCESS cycle and SHALL hold their last values in IDLE.
REQ-020 In ACCESS, PREADY=1 SHALL end the transfer: next cycle FSM in IDLE, PSEL=PENABLE=0, reqN_ack=1, reqN_err=0 for the granted N.
REQ-021 On a completed read, reqN_rdata SHALL capture PRDATA sampled with PREADY=1; on writes reqN_rdata SHALL hold.
REQ-022 With TIMEOUT>0 and PREADY low for TIMEOUT consecutive ACCESS cycles, SHALL return to IDLE with reqN_ack=1, reqN_err=1, reqN_rdata=0x00.
REQ-023 PREADY and PRDATA SHALL be ignored outside ACCESS; the timeout counter SHALL clear on entering SETUP.
REQ-024 Minimum transfer latency SHALL be 3 cycles from grant-cycle valid to ack (IDLE, SETUP, ACCESS with PREADY=1).
REQ-025 Requesters SHALL hold valid and request fields stable until ack; changes after the grant cycle SHALL not affect the transfer in flight.

Reset
REQ-026 PRESET high SHALL immediately force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0x00, all ack/err=0, all rdata=0x00, counter 0, round-robin pointer to requester 0.
REQ-027 Reset during SETUP or ACCESS SHALL abandon the transfer with no ack issued; the first transfer after reset SHALL behave as from power-up.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, SETUP, ACCESS) and the UART register-address constants.
REQ-029 The round-robin arbiter SHALL be one sub-module, apb_rr_arb2 (2 requests, mask, grant, last-grant pointer).

Verification
REQ-030 req0 write 0xD4 to 0x04, PREADY low 2 ACCESS cycles -> PSEL high 4 cycles, PENABLE 3, PADDR=0x04, PWDATA=0xD4 stable, req0_ack pulse, err=0.
REQ-031 req1 read 0x0C, PRDATA=0x5A with PREADY=1 first ACCESS cycle -> req1_ack 3 cycles after grant, req1_rdata=0x5A.
REQ-032 req0 and req1 both valid after reset -> req0 served first, then req1; a new tie next -> req0 served.
REQ-033 TIMEOUT=16, PREADY held low -> exactly 16 ACCESS cycles, then ack with err=1, rdata=0x00, busy low.
REQ-034 PRESET pulsed mid-ACCESS -> all outputs zero immediately, no ack; the next request completes normally with requester 0 favored.
REQ-035 PREADY=1 and PRDATA=0xFF in IDLE/SETUP -> no early completion, no rdata change.
